// File: rtl/als_backlight_gain.sv
// rtl/als_backlight_gain.sv - ambient-light conditioned, frame-synchronous backlight gain for the 360-zone stream
module als_backlight_gain #(
  parameter int SAMPLE_DIV = 500000,
  parameter int IIR_SHIFT  = 3,
  parameter int GAIN_MIN   = 32,
  parameter int GAIN_MAX   = 255,
  parameter int HYST       = 4
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [7:0] I_bright,
  input  logic       I_frame_start,
  input  logic       I_zone_vld,
  input  logic [7:0] I_zone_data,
  output logic       O_zone_vld,
  output logic [7:0] O_zone_data,
  output logic [7:0] O_gain,
  output logic       O_gain_upd
);

  localparam int            CW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int            AW       = 8 + IIR_SHIFT;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0] ACC_INIT = AW'(255) << IIR_SHIFT;
  localparam logic [7:0]    G_MIN    = 8'(GAIN_MIN);
  localparam logic [7:0]    G_MAX    = 8'(GAIN_MAX);

  typedef enum logic [2:0] {IDLE, SAMPLE, MEDIAN, FILTER, MAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [7:0]    s;
  logic [7:0]    m;
  logic [7:0]    h0;
  logic [7:0]    h1;
  logic [AW-1:0] acc;
  logic [7:0]    pending;

  logic [7:0]    lo;
  logic [7:0]    hi;
  logic [7:0]    med;
  logic [AW-1:0] acc_next;
  logic [7:0]    f;
  logic [7:0]    target;
  logic [7:0]    diff;
  logic          move;

  logic          vld1;
  logic [15:0]   p;
  logic [15:0]   prod;
  logic [15:0]   sum;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Median of three rejects a single-sample glitch from the sensor.
  always_comb begin
    lo  = (h1 < h0) ? h1 : h0;
    hi  = (h1 < h0) ? h0 : h1;
    med = s;
    if (s < lo) begin
      med = lo;
    end else if (s > hi) begin
      med = hi;
    end
  end

  always_comb begin
    acc_next = acc - (acc >> IIR_SHIFT) + AW'(m);
    f        = 8'(acc >> IIR_SHIFT);
    target   = f;
    if (f < G_MIN) begin
      target = G_MIN;
    end else if (f > G_MAX) begin
      target = G_MAX;
    end
    diff = (target >= pending) ? (target - pending) : (pending - target);
    // The rails are always reachable, even when closer than the hysteresis band.
    move = (int'(diff) >= HYST) ||
           (((target == G_MIN) || (target == G_MAX)) && (target != pending));
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= IDLE;
      s       <= '0;
      m       <= '0;
      h0      <= 8'hFF;
      h1      <= 8'hFF;
      acc     <= ACC_INIT;
      pending <= G_MAX;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          s     <= I_bright;
          state <= MEDIAN;
        end
        MEDIAN: begin
          m     <= med;
          h1    <= h0;
          h0    <= s;
          state <= FILTER;
        end
        FILTER: begin
          acc   <= acc_next;
          state <= MAP;
        end
        MAP: begin
          if (move) begin
            pending <= target;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign prod = 16'(I_zone_data) * 16'(O_gain);
  assign sum  = p + 16'd255;

  // Gain only moves on a frame boundary so a frame is never scaled by two gains.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_gain      <= G_MAX;
      O_gain_upd  <= 1'b0;
      vld1        <= 1'b0;
      p           <= '0;
      O_zone_vld  <= 1'b0;
      O_zone_data <= '0;
    end else begin
      O_gain_upd <= 1'b0;
      if (I_frame_start && (pending != O_gain)) begin
        O_gain     <= pending;
        O_gain_upd <= 1'b1;
      end
      vld1 <= I_zone_vld;
      if (I_zone_vld) begin
        p <= prod;
      end
      O_zone_vld <= vld1;
      if (vld1) begin
        O_zone_data <= 8'(sum >> 8);
      end
    end
  end

endmodule

// File: tb/tb_als_backlight_gain.sv
// tb/tb_als_backlight_gain.sv - directed bench for als_backlight_gain with SAMPLE_DIV=16
module tb_als_backlight_gain;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bright = 8'd100;
  logic       fs = 1'b0;
  logic       zone_vld = 1'b0;
  logic [7:0] zone_data = 8'd0;
  logic       out_vld;
  logic [7:0] out_data;
  logic [7:0] gain;
  logic       gain_upd;

  int checks = 0;
  int errors = 0;
  int cyc;
  int bad;

  typedef struct {
    logic [7:0] gain;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  als_backlight_gain #(
    .SAMPLE_DIV(16),
    .IIR_SHIFT (3),
    .GAIN_MIN  (32),
    .GAIN_MAX  (255),
    .HYST      (4)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_bright     (bright),
    .I_frame_start(fs),
    .I_zone_vld   (zone_vld),
    .I_zone_data  (zone_data),
    .O_zone_vld   (out_vld),
    .O_zone_data  (out_data),
    .O_gain       (gain),
    .O_gain_upd   (gain_upd)
  );

  // Cycle index since reset release; equals the DUT tick counter phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] g, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.gain = g;
    v.data = d;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic apply_zone(input logic [7:0] d, input logic [7:0] e);
    @(posedge clk); #1;
    zone_vld  = 1'b1;
    zone_data = d;
    @(posedge clk); #1;
    zone_vld  = 1'b0;
    zone_data = 8'hA5;
    check("zone_vld_lag1", out_vld, 0);
    @(posedge clk); #1;
    check("zone_vld_lag2", out_vld, 1);
    check("zone_data", out_data, e);
    @(posedge clk); #1;
    check("zone_vld_after", out_vld, 0);
    check("zone_data_hold", out_data, e);
  endtask

  task automatic run_table(input logic [7:0] g);
    check("table_gain", gain, g);
    foreach (vecs[i]) begin
      if (vecs[i].gain == g) apply_zone(vecs[i].data, vecs[i].exp);
    end
  endtask

  // Streams zones at gain 255, where the output must equal the input two cycles later.
  task automatic stream_identity(input int n, output int nbad);
    logic [7:0] q[$];
    nbad = 0;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        if (!out_vld || q.size() == 0 || out_data != q.pop_front()) nbad++;
      end
      if (i < n) begin
        zone_vld  = 1'b1;
        zone_data = 8'($urandom);
        q.push_back(zone_data);
      end else begin
        zone_vld = 1'b0;
      end
    end
  endtask

  task automatic pulse_frame(input string name, input logic [7:0] g, input logic u);
    @(posedge clk); #1;
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    check({name, "_gain"}, gain, g);
    check({name, "_upd"}, gain_upd, u);
    @(posedge clk); #1;
    check({name, "_upd_clear"}, gain_upd, 0);
  endtask

  task automatic wait_cyc(input int target, input bit use_mod);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((use_mod ? ((cyc % 16 != target) || cyc < 18) : (cyc != target)) && n < 200);
    check("wait_cyc_reached", (n < 200) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    add_vec(8'd255, 8'd0,   8'd0);
    add_vec(8'd255, 8'd1,   8'd1);
    add_vec(8'd255, 8'd77,  8'd77);
    add_vec(8'd255, 8'd128, 8'd128);
    add_vec(8'd255, 8'd200, 8'd200);
    add_vec(8'd255, 8'd255, 8'd255);
    add_vec(8'd100, 8'd200, 8'd79);
    add_vec(8'd100, 8'd255, 8'd100);
    add_vec(8'd100, 8'd1,   8'd1);
    add_vec(8'd100, 8'd0,   8'd0);
    add_vec(8'd100, 8'd128, 8'd50);
    add_vec(8'd100, 8'd10,  8'd4);
    add_vec(8'd32,  8'd200, 8'd25);
    add_vec(8'd32,  8'd255, 8'd32);
    add_vec(8'd32,  8'd1,   8'd1);
    add_vec(8'd40,  8'd200, 8'd32);
    add_vec(8'd40,  8'd255, 8'd40);
    add_vec(8'd40,  8'd3,   8'd1);

    // Reset with zones already streaming.
    zone_vld  = 1'b1;
    zone_data = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gain", gain, 255);
    check("rst_upd", gain_upd, 0);
    check("rst_zone_vld", out_vld, 0);
    check("rst_zone_data", out_data, 0);
    check("rst_acc", dut.acc, 2040);
    rst_n = 1'b1;
    stream_identity(40, bad);
    check("identity_after_reset", bad, 0);
    run_table(8'd255);

    // Ambient 100 settles pending at 100, but no frame start means the old gain stays.
    stream_identity(1000, bad);
    check("no_frame_zones_old_gain", bad, 0);
    check("no_frame_gain_held", gain, 255);
    pulse_frame("settle_100", 8'd100, 1'b1);
    run_table(8'd100);

    // One sample window of 0 must be absorbed by the median.
    @(posedge clk); #1;
    bright = 8'd0;
    repeat (16) @(posedge clk);
    #1;
    bright = 8'd100;
    repeat (200) @(posedge clk);
    pulse_frame("glitch", 8'd100, 1'b0);

    bright = 8'd5;
    repeat (1000) @(posedge clk);
    pulse_frame("clamp_min", 8'd32, 1'b1);
    run_table(8'd32);

    bright = 8'd34;
    repeat (1000) @(posedge clk);
    pulse_frame("hyst_hold", 8'd32, 1'b0);

    // Frame start coinciding with a zone: that zone gets 32, the next gets 40.
    bright = 8'd40;
    repeat (1000) @(posedge clk);
    @(posedge clk); #1;
    fs        = 1'b1;
    zone_vld  = 1'b1;
    zone_data = 8'd200;
    @(posedge clk); #1;
    fs = 1'b0;
    check("atomic_gain", gain, 40);
    check("atomic_upd", gain_upd, 1);
    @(posedge clk); #1;
    zone_vld = 1'b0;
    check("atomic_upd_clear", gain_upd, 0);
    check("atomic_old_vld", out_vld, 1);
    check("atomic_old_data", out_data, 25);
    @(posedge clk); #1;
    check("atomic_new_vld", out_vld, 1);
    check("atomic_new_data", out_data, 32);
    @(posedge clk); #1;
    check("atomic_end_vld", out_vld, 0);
    run_table(8'd40);

    // Reset asserted while the FSM is in FILTER.
    zone_vld  = 1'b1;
    zone_data = 8'd150;
    bright    = 8'd100;
    wait_cyc(2, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_gain", gain, 255);
    check("midrst_zone_vld", out_vld, 0);
    check("midrst_zone_data", out_data, 0);
    check("midrst_upd", gain_upd, 0);
    check("midrst_acc", dut.acc, 2040);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    zone_vld = 1'b0;

    // Second sample's MAP (cycle 35) moves pending to 235 in the frame-start cycle.
    wait_cyc(35, 1'b0);
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    check("deferred_gain", gain, 255);
    check("deferred_upd", gain_upd, 0);
    pulse_frame("deferred_next", 8'd235, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
